sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 31 +++
 rtl/sram_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encoding and port indices.
// Latency: n/a (constants and a decode helper only).
// Backpressure: n/a.
package sram_arbiter_pkg;

   // FSM state encoding; kept as plain constants so legacy tools see fixed codes.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GRANT0 = 2'd1;
   localparam logic [1:0] ST_GRANT1 = 2'd2;

   // Requester indices, also the encoding of the remembered last owner.
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // One-hot controller owner for a given state (00 when idle).
   function automatic logic [1:0] state_to_grant(input logic [1:0] st);
      logic [1:0] g;
      g = 2'b00;
      if (st == ST_GRANT0) g = 2'b01;
      if (st == ST_GRANT1) g = 2'b10;
      return g;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way tie-break: picks the winning port index from a 2-bit request vector.
// Latency: purely combinational.
// Backpressure: none; the caller registers the decision.
//
// Ports:
//   req[1:0]  - request from port 1 / port 0
//   lastGrant - index of the port that completed most recently
//   winner    - index of the port to serve (don't-care when req == 00)
module rr_pick2
   import sram_arbiter_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0] req,
   input  logic       lastGrant,
   output logic       winner
);

   always_comb begin
      winner = PORT0;
      case (req)
         2'b01:   winner = PORT0;
         2'b10:   winner = PORT1;
         // Contention: fixed mode always favours port 0, otherwise serve the
         // port that did not go last.
         2'b11:   winner = (FIXED_PRIO != 0) ? PORT0 : ~lastGrant;
         default: winner = PORT0;
      endcase
   end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters (MEM-stage data, fetch) onto one SRAM controller.
// Latency: one registered IDLE cycle to grant, then held until memReady; one IDLE cycle between grants.
// Backpressure: readyK low while port K requests and its transaction has not completed.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   wrEnK, rdEnK, addressK,
//   writeDataK                    - port K request (K = 0, 1)
//   readDataK, readyK             - port K load data and ready/stall
//   memWrEn, memRdEn, memAddress,
//   memWriteData                  - latched request towards the SRAM controller
//   memReadData, memReady         - controller response (memReady pulses at completion)
//   grant, busy                   - one-hot current owner, and owner != none
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrEn0,
   input  logic        rdEn0,
   input  logic [31:0] address0,
   input  logic [31:0] writeData0,
   output logic [31:0] readData0,
   output logic        ready0,
   input  logic        wrEn1,
   input  logic        rdEn1,
   input  logic [31:0] address1,
   input  logic [31:0] writeData1,
   output logic [31:0] readData1,
   output logic        ready1,
   output logic        memWrEn,
   output logic        memRdEn,
   output logic [31:0] memAddress,
   output logic [31:0] memWriteData,
   input  logic [31:0] memReadData,
   input  logic        memReady,
   output logic [1:0]  grant,
   output logic        busy
);

   logic [1:0]  state;
   logic        last_grant;
   logic        lat_wr;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] rdata_reg0;
   logic [31:0] rdata_reg1;

   logic        req0;
   logic        req1;
   logic        winner;
   logic        granted;
   logic        done0;
   logic        done1;

   assign req0 = wrEn0 | rdEn0;
   assign req1 = wrEn1 | rdEn1;

   rr_pick2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .req       ({req1, req0}),
      .lastGrant (last_grant),
      .winner    (winner)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         last_grant <= PORT1;   // so port 0 wins the first tie
         lat_wr     <= 1'b0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         rdata_reg0 <= 32'd0;
         rdata_reg1 <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               // memReady is deliberately ignored here.
               if (req0 || req1) begin
                  state     <= (winner == PORT1) ? ST_GRANT1 : ST_GRANT0;
                  // Write takes precedence when both enables are set.
                  lat_wr    <= (winner == PORT1) ? wrEn1 : wrEn0;
                  lat_addr  <= (winner == PORT1) ? address1 : address0;
                  lat_wdata <= (winner == PORT1) ? writeData1 : writeData0;
               end
            end
            ST_GRANT0: begin
               if (memReady) begin
                  state      <= ST_IDLE;
                  last_grant <= PORT0;
                  if (!lat_wr) rdata_reg0 <= memReadData;
               end
            end
            ST_GRANT1: begin
               if (memReady) begin
                  state      <= ST_IDLE;
                  last_grant <= PORT1;
                  if (!lat_wr) rdata_reg1 <= memReadData;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Controller side drives only from the latches, so requester changes
   // (including dropping the request) cannot disturb an issued transaction.
   assign granted      = (state == ST_GRANT0) || (state == ST_GRANT1);
   assign memWrEn      = granted &  lat_wr;
   assign memRdEn      = granted & ~lat_wr;
   assign memAddress   = lat_addr;
   assign memWriteData = lat_wdata;

   assign grant = state_to_grant(state);
   assign busy  = |grant;

   // Completion cycle forwards the controller data straight through.
   assign done0 = (state == ST_GRANT0) && memReady;
   assign done1 = (state == ST_GRANT1) && memReady;

   assign ready0    = done0 | ~req0;
   assign ready1    = done1 | ~req1;
   assign readData0 = done0 ? memReadData : rdata_reg0;
   assign readData1 = done1 ? memReadData : rdata_reg1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: arbitration table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
// Second instance with FIXED_PRIO=1 shares the inputs for the fixed-priority contention check.
module tb_sram_arbiter;

   logic        clk;
   logic        rst;
   logic        wrEn0, rdEn0, wrEn1, rdEn1;
   logic [31:0] address0, writeData0, address1, writeData1;
   logic [31:0] readData0, readData1;
   logic        ready0, ready1;
   logic        memWrEn, memRdEn;
   logic [31:0] memAddress, memWriteData;
   logic [31:0] memReadData;
   logic        memReady;
   logic [1:0]  grant;
   logic        busy;

   logic [31:0] f_readData0, f_readData1, f_memAddress, f_memWriteData;
   logic        f_ready0, f_ready1, f_memWrEn, f_memRdEn, f_busy;
   logic [1:0]  f_grant;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] last_rd1;

   sram_arbiter #(.FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .wrEn0(wrEn0), .rdEn0(rdEn0), .address0(address0), .writeData0(writeData0),
      .readData0(readData0), .ready0(ready0),
      .wrEn1(wrEn1), .rdEn1(rdEn1), .address1(address1), .writeData1(writeData1),
      .readData1(readData1), .ready1(ready1),
      .memWrEn(memWrEn), .memRdEn(memRdEn), .memAddress(memAddress),
      .memWriteData(memWriteData), .memReadData(memReadData), .memReady(memReady),
      .grant(grant), .busy(busy)
   );

   sram_arbiter #(.FIXED_PRIO(1)) u_fixed (
      .clk(clk), .rst(rst),
      .wrEn0(wrEn0), .rdEn0(rdEn0), .address0(address0), .writeData0(writeData0),
      .readData0(f_readData0), .ready0(f_ready0),
      .wrEn1(wrEn1), .rdEn1(rdEn1), .address1(address1), .writeData1(writeData1),
      .readData1(f_readData1), .ready1(f_ready1),
      .memWrEn(f_memWrEn), .memRdEn(f_memRdEn), .memAddress(f_memAddress),
      .memWriteData(f_memWriteData), .memReadData(memReadData), .memReady(memReady),
      .grant(f_grant), .busy(f_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr0, rd0, wr1, rd1;
      logic [31:0] a0, a1;
      logic [1:0]  exp_grant;
      logic        exp_wr, exp_rd;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      wrEn0 = 0; rdEn0 = 0; wrEn1 = 0; rdEn1 = 0;
      memReady = 0; memReadData = 32'd0;
   endtask

   // Reference model state (transaction level).
   int          m_owner;
   int          m_last;
   int          m_lat;
   logic        m_wr;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rreg[2];

   initial begin
      logic [1:0]  eg;
      logic [31:0] rd_exp;
      logic        c0, c1;
      logic        r0, r1;
      int          win;

      vecs[0] = '{1'b0,1'b0,1'b0,1'b0, 32'h1000, 32'h2000, 2'b00, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b0,1'b1,1'b0,1'b0, 32'h1004, 32'h2004, 2'b01, 1'b0, 1'b1, 32'h1004};
      vecs[2] = '{1'b0,1'b0,1'b1,1'b0, 32'h1008, 32'h2008, 2'b10, 1'b1, 1'b0, 32'h2008};
      vecs[3] = '{1'b1,1'b1,1'b0,1'b0, 32'h100C, 32'h200C, 2'b01, 1'b1, 1'b0, 32'h100C};
      vecs[4] = '{1'b0,1'b1,1'b0,1'b1, 32'h1010, 32'h2010, 2'b10, 1'b0, 1'b1, 32'h2010};
      vecs[5] = '{1'b1,1'b0,1'b1,1'b1, 32'h1014, 32'h2014, 2'b01, 1'b1, 1'b0, 32'h1014};
      vecs[6] = '{1'b0,1'b0,1'b1,1'b1, 32'h1018, 32'h2018, 2'b10, 1'b1, 1'b0, 32'h2018};

      rst = 0;
      address0 = 0; address1 = 0; writeData0 = 0; writeData1 = 0;
      clear_inputs();
      last_rd1 = 32'd0;
      #2;
      chk("rst.grant", grant, 0);
      chk("rst.busy", busy, 0);
      chk("rst.memWrEn", memWrEn, 0);
      chk("rst.memRdEn", memRdEn, 0);
      chk("rst.memAddress", memAddress, 0);
      chk("rst.memWriteData", memWriteData, 0);
      chk("rst.readData0", readData0, 0);
      chk("rst.readData1", readData1, 0);
      next_cycle();
      next_cycle();
      rst = 1;

      // memReady in IDLE with no requests is ignored.
      next_cycle(); memReady = 1; memReadData = 32'hFFFF_0000; settle();
      chk("idle_rdy.ready0", ready0, 1);
      chk("idle_rdy.ready1", ready1, 1);
      chk("idle_rdy.grant", grant, 0);
      next_cycle(); clear_inputs(); settle();
      chk("idle_rdy.grant_after", grant, 0);
      chk("idle_rdy.readData0", readData0, 0);

      // Arbitration table.
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         wrEn0 = vecs[i].wr0; rdEn0 = vecs[i].rd0;
         wrEn1 = vecs[i].wr1; rdEn1 = vecs[i].rd1;
         address0 = vecs[i].a0; address1 = vecs[i].a1;
         writeData0 = 32'hA000_0000 + i; writeData1 = 32'hB000_0000 + i;
         settle();
         chk($sformatf("v%0d.registered_grant", i), grant, 0);
         chk($sformatf("v%0d.idle_en", i), memWrEn | memRdEn, 0);
         next_cycle(); settle();
         chk($sformatf("v%0d.grant", i), grant, vecs[i].exp_grant);
         chk($sformatf("v%0d.memWrEn", i), memWrEn, vecs[i].exp_wr);
         chk($sformatf("v%0d.memRdEn", i), memRdEn, vecs[i].exp_rd);
         if (vecs[i].exp_grant != 2'b00) begin
            chk($sformatf("v%0d.memAddress", i), memAddress, vecs[i].exp_addr);
            memReady = 1; memReadData = 32'h7700_0000 + i; settle();
            chk($sformatf("v%0d.ready", i), vecs[i].exp_grant[1] ? ready1 : ready0, 1);
            chk($sformatf("v%0d.readData", i), vecs[i].exp_grant[1] ? readData1 : readData0,
                32'h7700_0000 + i);
            if (vecs[i].exp_grant[1] && vecs[i].exp_rd) last_rd1 = 32'h7700_0000 + i;
         end
         next_cycle(); clear_inputs(); settle();
         chk($sformatf("v%0d.back_idle", i), grant, 0);
      end

      // Sustained contention: 0,1,0,1 round-robin, always 0 in fixed mode.
      for (int t = 0; t < 4; t++) begin
         next_cycle(); rdEn0 = 1; rdEn1 = 1; memReady = 0; settle();
         chk($sformatf("alt%0d.turnaround", t), grant, 0);
         chk($sformatf("alt%0d.fixed_turnaround", t), f_grant, 0);
         next_cycle(); settle();
         chk($sformatf("alt%0d.grant", t), grant, (t % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("alt%0d.fixed_grant", t), f_grant, 2'b01);
         memReady = 1; memReadData = 32'h5000_0000 + t;
         if (t % 2 == 1) last_rd1 = 32'h5000_0000 + t;
      end
      next_cycle(); clear_inputs(); settle();

      // Port 0 read with a five-cycle controller.
      next_cycle(); rdEn0 = 1; address0 = 32'h0000_0408; settle();
      chk("rd408.ready0_req", ready0, 0);
      next_cycle(); settle();
      chk("rd408.grant", grant, 2'b01);
      chk("rd408.memAddress", memAddress, 32'h0000_0408);
      chk("rd408.memRdEn", memRdEn, 1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rd408.wait%0d_ready0", k), ready0, 0);
         next_cycle(); settle();
      end
      memReady = 1; memReadData = 32'h1234_5678; settle();
      chk("rd408.done_ready0", ready0, 1);
      chk("rd408.done_readData0", readData0, 32'h1234_5678);
      next_cycle(); clear_inputs(); rdEn0 = 1; settle();
      chk("rd408.ready0_after", ready0, 0);
      chk("rd408.held_readData0", readData0, 32'h1234_5678);
      chk("rd408.grant_after", grant, 0);
      rdEn0 = 0;

      // Port 1 write+read: write wins, read register untouched.
      next_cycle(); wrEn1 = 1; rdEn1 = 1; address1 = 32'h500; writeData1 = 32'hDEAD_BEEF; settle();
      next_cycle(); settle();
      chk("wr500.grant", grant, 2'b10);
      chk("wr500.memWrEn", memWrEn, 1);
      chk("wr500.memRdEn", memRdEn, 0);
      chk("wr500.memAddress", memAddress, 32'h500);
      chk("wr500.memWriteData", memWriteData, 32'hDEAD_BEEF);
      memReady = 1; memReadData = 32'hCAFE_F00D; settle();
      chk("wr500.ready1", ready1, 1);
      next_cycle(); clear_inputs(); settle();
      chk("wr500.rdataReg1", readData1, last_rd1);

      // Address change mid-grant does not reach the controller.
      next_cycle(); rdEn0 = 1; address0 = 32'h400; settle();
      next_cycle(); settle();
      chk("addr.latched", memAddress, 32'h400);
      next_cycle(); address0 = 32'h800; settle();
      chk("addr.hold1", memAddress, 32'h400);
      next_cycle(); rdEn0 = 0; settle();
      chk("addr.hold2", memAddress, 32'h400);
      chk("addr.still_granted", grant, 2'b01);
      memReady = 1; settle();
      chk("addr.hold_done", memAddress, 32'h400);
      next_cycle(); clear_inputs(); settle();

      // Reset during GRANT1.
      next_cycle(); rdEn1 = 1; settle();
      next_cycle(); settle();
      chk("rstg.grant1", grant, 2'b10);
      rst = 0; #1;
      chk("rstg.grant", grant, 0);
      chk("rstg.busy", busy, 0);
      chk("rstg.en", {memWrEn, memRdEn}, 0);
      chk("rstg.readData0", readData0, 0);
      chk("rstg.readData1", readData1, 0);
      next_cycle(); rst = 1; rdEn0 = 1; rdEn1 = 1; settle();
      chk("rstg.idle", grant, 0);
      next_cycle(); settle();
      chk("rstg.first_tie", grant, 2'b01);
      memReady = 1;
      next_cycle(); clear_inputs();

      // Randomized run against the reference model.
      rst = 0;
      next_cycle(); rst = 1;
      m_owner = -1; m_last = 1; m_lat = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
      m_rreg[0] = 0; m_rreg[1] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         next_cycle();
         if ($urandom_range(0, 3) == 0) {wrEn0, rdEn0} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) {wrEn1, rdEn1} = 2'($urandom_range(0, 3));
         address0 = $urandom; address1 = $urandom;
         writeData0 = $urandom; writeData1 = $urandom;
         memReadData = $urandom;
         if (m_owner >= 0) begin
            if (m_lat == 0) memReady = 1;
            else begin memReady = 0; m_lat--; end
         end else begin
            memReady = ($urandom_range(0, 3) == 0);
         end
         settle();

         eg = (m_owner < 0) ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
         c0 = (m_owner == 0) && memReady;
         c1 = (m_owner == 1) && memReady;
         r0 = wrEn0 | rdEn0;
         r1 = wrEn1 | rdEn1;
         chk("rnd.grant", grant, eg);
         chk("rnd.busy", busy, m_owner >= 0);
         chk("rnd.memWrEn", memWrEn, (m_owner >= 0) && m_wr);
         chk("rnd.memRdEn", memRdEn, (m_owner >= 0) && !m_wr);
         if (m_owner >= 0) begin
            chk("rnd.memAddress", memAddress, m_addr);
            chk("rnd.memWriteData", memWriteData, m_wdata);
         end
         chk("rnd.ready0", ready0, c0 ? 1'b1 : !r0);
         chk("rnd.ready1", ready1, c1 ? 1'b1 : !r1);
         rd_exp = c0 ? memReadData : m_rreg[0];
         chk("rnd.readData0", readData0, rd_exp);
         rd_exp = c1 ? memReadData : m_rreg[1];
         chk("rnd.readData1", readData1, rd_exp);

         if (m_owner >= 0) begin
            if (memReady) begin
               if (!m_wr) m_rreg[m_owner] = memReadData;
               m_last = m_owner;
               m_owner = -1;
            end
         end else if (r0 || r1) begin
            if (r0 && r1) win = (m_last == 0) ? 1 : 0;
            else win = r1 ? 1 : 0;
            m_owner = win;
            m_wr    = win ? wrEn1 : wrEn0;
            m_addr  = win ? address1 : address0;
            m_wdata = win ? writeData1 : writeData0;
            m_lat   = $urandom_range(0, 3);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
